// File: rtl/event_pkg.sv
// Shared constants and FSM state type for the event_pending8 slice.
package event_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/Or8Way.sv
// 8-input OR reduction used for the any_pending flag.
module Or8Way (
    input  logic [7:0] in,
    output logic       out
);

    // Reduce all eight inputs to a single flag.
    always_comb begin
        out = |in;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Combinational round-robin picker over 8 requests, starting at ptr.
module rr_arbiter8 import event_pkg::*; (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);

    // Scan ptr, ptr+1, ... (wrapping 7->0) and take the first set request.
    always_comb begin
        logic [IDX_W-1:0] pos;
        idx = '0;
        hit = 1'b0;
        pos = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = ptr + IDX_W'(k);
            if (!hit && req[pos]) begin
                hit = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/event_pending8.sv
// Sticky pending-bit capture for 8 event lines with round-robin grant offer.
// Optional feature: define EVT_MASK_EN to add a mask input that excludes bits
// from arbitration and from any_pending while still latching them.
module event_pending8 import event_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     evt,
    output logic [N-1:0]     pending,
    output logic             any_pending,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    input  logic             gnt_ready,
    output logic             ovf,
    input  logic             clr_ovf
`ifdef EVT_MASK_EN
    ,
    input  logic [N-1:0]     mask
`endif
);

    state_t           state, state_n;
    logic [N-1:0]     evt_q;
    logic [N-1:0]     rise;
    logic [N-1:0]     clr;
    logic [N-1:0]     pending_n;
    logic [N-1:0]     eligible;
    logic             ovf_n;
    logic             accept;
    logic [IDX_W-1:0] gnt_idx_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_hit;

`ifdef EVT_MASK_EN
    assign eligible = pending & ~mask;
`else
    assign eligible = pending;
`endif

    assign accept = (state == OFFER) && gnt_ready;

    rr_arbiter8 u_arb (
        .req (eligible),
        .ptr (rr_ptr),
        .idx (arb_idx),
        .hit (arb_hit)
    );

    Or8Way u_or (
        .in  (eligible),
        .out (any_pending)
    );

    // Edge detect, pending set/clear (set wins) and sticky overflow.
    always_comb begin
        rise = evt & ~evt_q;
        clr  = '0;
        if (accept) begin
            clr[gnt_idx] = 1'b1;
        end
        pending_n = rise | (pending & ~clr);
        if (|(rise & pending & ~clr)) begin
            ovf_n = 1'b1;
        end else if (clr_ovf) begin
            ovf_n = 1'b0;
        end else begin
            ovf_n = ovf;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q   <= '0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            evt_q   <= evt;
            pending <= pending_n;
            ovf     <= ovf_n;
        end
    end

    // Grant FSM next-state and outputs.
    always_comb begin
        state_n   = state;
        gnt_idx_n = gnt_idx;
        rr_ptr_n  = rr_ptr;
        gnt_valid = 1'b0;
        case (state)
            IDLE: begin
                if (arb_hit) begin
                    state_n   = OFFER;
                    gnt_idx_n = arb_idx;
                end
            end
            OFFER: begin
                gnt_valid = 1'b1;
                if (gnt_ready) begin
                    rr_ptr_n = gnt_idx + 1'b1;
                    state_n  = GAP;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Grant FSM state, held index and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_idx <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_n;
            gnt_idx <= gnt_idx_n;
            rr_ptr  <= rr_ptr_n;
        end
    end

endmodule
